mem_stage: RTL and testbench

Memory-access stage of the five-stage RISC-V pipeline. It consumes the EX/MEM register outputs, performs byte/half/word loads and stores against an internal synchronous data RAM, and registers the results into the MEM/WB boundary for write-back. All outputs are registered, so the block replaces a separate MEM/WB register.

---
 rtl/mem_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the five-stage RISC-V pipeline. It takes the EX/MEM
// register outputs, performs byte/half/word loads and stores against an
// internal 32-bit-wide data RAM with per-byte write enables, and registers
// everything the write-back stage needs. It therefore also serves as the
// MEM/WB pipeline register.
//
// Ports
//   clk            in   clock, all state changes on the rising edge
//   reset          in   synchronous, active-low reset
//   stall_in       in   hold all output registers and suppress the RAM write
//   MemOp_in[2:0]  in   access size/sign in funct3 encoding
//   MemRead_in     in   load request
//   MemWrite_in    in   store request (wins over MemRead_in)
//   ALUResult_in   in   effective address / ALU result
//   WriteData_in   in   store data (rs2)
//   rd_in[4:0]     in   destination register
//   RegWrite_in    in   register write enable
//   MemtoReg_in    in   write-back select, 1 = load data
//   ReadData_out   out  aligned and extended load data (0 when no load)
//   ALUResult_out  out  registered ALUResult_in
//   WBData_out     out  MemtoReg_out ? ReadData_out : ALUResult_out
//   rd_out         out  registered rd_in
//   RegWrite_out   out  registered write enable, cleared on a faulting access
//   MemtoReg_out   out  registered MemtoReg_in
//   misalign_out   out  registered misaligned/illegal access flag
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic [2:0]  MemOp_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] WriteData_in,
  input  logic [4:0]  rd_in,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUResult_out,
  output logic [31:0] WBData_out,
  output logic [4:0]  rd_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        misalign_out
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  // Byte lanes touched by a store; 100/101 fall through to byte/half since
  // only the size bits matter for writing.
  function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] off);
    case (op[1:0])
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate the store data across lanes so the byte enables pick the
  // correct copy without a lane shifter.
  function automatic logic [DATA_W-1:0] store_data(input logic [2:0] op,
                                                   input logic [DATA_W-1:0] wd);
    case (op[1:0])
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  // Extract and extend the addressed byte/half; op[2] selects zero-extension.
  function automatic logic [DATA_W-1:0] load_data(input logic [2:0] op,
                                                  input logic [1:0] off,
                                                  input logic [DATA_W-1:0] word);
    logic [DATA_W-1:0] sh;
    sh = word >> {off, 3'b000};
    case (op[1:0])
      2'b00:   load_data = op[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
      2'b01:   load_data = op[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_data = word;
    endcase
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            byte_off;
  logic                  access;
  logic                  illegal_op;
  logic                  misaligned;
  logic                  fault;
  logic                  wr_req;
  logic [3:0]            wr_be;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W-1:0]     rd_word;

  logic [DATA_W-1:0] readdata_d, readdata_q;
  logic [DATA_W-1:0] aluresult_d, aluresult_q;
  logic [4:0]        rd_d, rd_q;
  logic              regwrite_d, regwrite_q;
  logic              memtoreg_d, memtoreg_q;
  logic              misalign_d, misalign_q;

  // Upper address bits are ignored: the RAM aliases modulo its size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ALUResult_in[DATA_W-1:ADDR_WIDTH+2];

  assign word_idx = ALUResult_in[ADDR_WIDTH+1:2];
  assign byte_off = ALUResult_in[1:0];
  assign rd_word  = mem[word_idx];

  always_comb begin
    access      = MemRead_in | MemWrite_in;
    // 011, 110 and 111 are not valid load/store encodings.
    illegal_op  = (MemOp_in[1:0] == 2'b11) | (MemOp_in[2] & MemOp_in[1]);
    case (MemOp_in[1:0])
      2'b01:   misaligned = byte_off[0];
      2'b10:   misaligned = (byte_off != 2'b00);
      default: misaligned = 1'b0;
    endcase
    fault       = access & (illegal_op | misaligned);
    wr_req      = MemWrite_in & ~fault;
    wr_be       = byte_en(MemOp_in, byte_off);
    wr_data     = store_data(MemOp_in, WriteData_in);

    readdata_d  = '0;
    if (MemRead_in && !MemWrite_in && !fault)
      readdata_d = load_data(MemOp_in, byte_off, rd_word);
    aluresult_d = ALUResult_in;
    rd_d        = rd_in;
    regwrite_d  = RegWrite_in & ~fault;
    memtoreg_d  = MemtoReg_in;
    misalign_d  = fault;
  end

  // RAM write: contents are never reset; reset and stall both block the write.
  always_ff @(posedge clk) begin
    if (reset && !stall_in && wr_req) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b])
          mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // MEM/WB boundary
  always_ff @(posedge clk) begin
    if (!reset) begin
      readdata_q  <= '0;
      aluresult_q <= '0;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      misalign_q  <= 1'b0;
    end else if (!stall_in) begin
      readdata_q  <= readdata_d;
      aluresult_q <= aluresult_d;
      rd_q        <= rd_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      misalign_q  <= misalign_d;
    end
  end

  assign ReadData_out  = readdata_q;
  assign ALUResult_out = aluresult_q;
  assign WBData_out    = memtoreg_q ? readdata_q : aluresult_q;
  assign rd_out        = rd_q;
  assign RegWrite_out  = regwrite_q;
  assign MemtoReg_out  = memtoreg_q;
  assign misalign_out  = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic [2:0]  MemOp_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [31:0] ALUResult_in;
  logic [31:0] WriteData_in;
  logic [4:0]  rd_in;
  logic        RegWrite_in;
  logic        MemtoReg_in;
  logic [31:0] ReadData_out;
  logic [31:0] ALUResult_out;
  logic [31:0] WBData_out;
  logic [4:0]  rd_out;
  logic        RegWrite_out;
  logic        MemtoReg_out;
  logic        misalign_out;

  int tests_run = 0;
  int tests_failed = 0;

  mem_stage #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in),
    .MemOp_in(MemOp_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .ALUResult_in(ALUResult_in), .WriteData_in(WriteData_in),
    .rd_in(rd_in), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .ReadData_out(ReadData_out), .ALUResult_out(ALUResult_out),
    .WBData_out(WBData_out), .rd_out(rd_out), .RegWrite_out(RegWrite_out),
    .MemtoReg_out(MemtoReg_out), .misalign_out(misalign_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction, clock it in, and return 1 time unit after the edge.
  task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic rw, input logic m2r);
    MemRead_in   = rd_en;
    MemWrite_in  = wr_en;
    MemOp_in     = op;
    ALUResult_in = addr;
    WriteData_in = wdata;
    rd_in        = rd;
    RegWrite_in  = rw;
    MemtoReg_in  = m2r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    stall_in = 1'b0;
    drive(1'b0, 1'b1, 3'b010, 32'h300, 32'h55AA55AA, 5'd3, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 3'b010, 32'h300, 32'h55AA55AA, 5'd3, 1'b1, 1'b1);
    tests_run++;
    if ({ReadData_out, ALUResult_out, WBData_out} !== 96'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h/%h/%h required 0/0/0", ReadData_out, ALUResult_out, WBData_out);
    end
    tests_run++;
    if ({rd_out, RegWrite_out, MemtoReg_out, misalign_out} !== 8'h0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got rd=%0d rw=%b m2r=%b mis=%b required all 0",
               rd_out, RegWrite_out, MemtoReg_out, misalign_out);
    end
    // Release: the instruction presented now is captured at this edge.
    reset = 1'b1;
    drive(1'b0, 1'b1, 3'b010, 32'h300, 32'h12345678, 5'd0, 1'b0, 1'b0);
    tests_run++;
    if (ALUResult_out !== 32'h300) begin
      tests_failed++;
      $display("FAIL reset_release: got %h required %h", ALUResult_out, 32'h300);
    end
    // Reset (with stall also asserted) over a store: outputs clear, store suppressed.
    reset    = 1'b0;
    stall_in = 1'b1;
    drive(1'b0, 1'b1, 3'b010, 32'h300, 32'h55AA55AA, 5'd3, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 3'b010, 32'h300, 32'h55AA55AA, 5'd3, 1'b1, 1'b1);
    tests_run++;
    if (ALUResult_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_over_stall: got %h required 0", ALUResult_out);
    end
    reset    = 1'b1;
    stall_in = 1'b0;
    drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd1, 1'b1, 1'b1);
    tests_run++;
    if (ReadData_out !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL reset_store_suppressed: got %h required %h", ReadData_out, 32'h12345678);
    end
  endtask

  task automatic test_word;
    drive(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0);
    tests_run++;
    if ({ReadData_out, misalign_out, ALUResult_out} !== {32'h0, 1'b0, 32'h100}) begin
      tests_failed++;
      $display("FAIL sw_outputs: got rdata=%h mis=%b alu=%h required 0/0/100",
               ReadData_out, misalign_out, ALUResult_out);
    end
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 1'b1, 1'b1);
    tests_run++;
    if ({ReadData_out, WBData_out} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("FAIL lw_data: got %h/%h required deadbeef/deadbeef", ReadData_out, WBData_out);
    end
    tests_run++;
    if ({rd_out, RegWrite_out, MemtoReg_out, misalign_out} !== {5'd5, 1'b1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL lw_ctrl: got rd=%0d rw=%b m2r=%b mis=%b required 5/1/1/0",
               rd_out, RegWrite_out, MemtoReg_out, misalign_out);
    end
  endtask

  task automatic test_subword;
    logic [31:0] exp [5];
    logic [2:0]  ops [5];
    logic [31:0] adr [5];
    // SB writes only the low byte of WriteData_in into lane 2.
    drive(1'b0, 1'b1, 3'b000, 32'h102, 32'h0000AB7F, 5'd0, 1'b0, 1'b0);
    ops[0] = 3'b000; adr[0] = 32'h103; exp[0] = 32'hFFFFFFDE;
    ops[1] = 3'b100; adr[1] = 32'h103; exp[1] = 32'h000000DE;
    ops[2] = 3'b001; adr[2] = 32'h102; exp[2] = 32'hFFFFDE7F;
    ops[3] = 3'b010; adr[3] = 32'h100; exp[3] = 32'hDE7FBEEF;
    ops[4] = 3'b101; adr[4] = 32'h100; exp[4] = 32'h0000BEEF;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, ops[i], adr[i], 32'h0, 5'd6, 1'b1, 1'b1);
      tests_run++;
      if (WBData_out !== exp[i]) begin
        tests_failed++;
        $display("FAIL subword_load_%0d: got %h required %h", i, WBData_out, exp[i]);
      end
    end
  endtask

  task automatic test_misalign;
    drive(1'b0, 1'b1, 3'b010, 32'h101, 32'h01020304, 5'd4, 1'b1, 1'b0);
    tests_run++;
    if ({misalign_out, RegWrite_out, ReadData_out} !== {1'b1, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL sw_misalign: got mis=%b rw=%b rdata=%h required 1/0/0",
               misalign_out, RegWrite_out, ReadData_out);
    end
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd4, 1'b1, 1'b1);
    tests_run++;
    if ({ReadData_out, misalign_out} !== {32'hDE7FBEEF, 1'b0}) begin
      tests_failed++;
      $display("FAIL word_unchanged: got %h mis=%b required de7fbeef mis=0", ReadData_out, misalign_out);
    end
    drive(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 5'd4, 1'b1, 1'b1);
    tests_run++;
    if ({ReadData_out, misalign_out, RegWrite_out} !== {32'h0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL lh_misalign: got rdata=%h mis=%b rw=%b required 0/1/0",
               ReadData_out, misalign_out, RegWrite_out);
    end
    drive(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 5'd4, 1'b1, 1'b1);
    tests_run++;
    if ({ReadData_out, misalign_out} !== {32'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL illegal_op: got rdata=%h mis=%b required 0/1", ReadData_out, misalign_out);
    end
    // Non-memory instruction with a junk MemOp never faults.
    drive(1'b0, 1'b0, 3'b111, 32'h00000033, 32'h0, 5'd9, 1'b1, 1'b0);
    tests_run++;
    if ({misalign_out, RegWrite_out, WBData_out} !== {1'b0, 1'b1, 32'h33}) begin
      tests_failed++;
      $display("FAIL alu_no_fault: got mis=%b rw=%b wb=%h required 0/1/33",
               misalign_out, RegWrite_out, WBData_out);
    end
  endtask

  task automatic test_stall;
    drive(1'b0, 1'b1, 3'b010, 32'h200, 32'h0BADF00D, 5'd0, 1'b0, 1'b0);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 3'b010, 32'h200, 32'h11111111, 5'd2, 1'b1, 1'b1);
      tests_run++;
      if ({ALUResult_out, rd_out, RegWrite_out} !== {32'h200, 5'd0, 1'b0}) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: got alu=%h rd=%0d rw=%b required 200/0/0",
                 i, ALUResult_out, rd_out, RegWrite_out);
      end
    end
    stall_in = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h42, 32'h0, 5'd7, 1'b1, 1'b0);
    tests_run++;
    if ({WBData_out, rd_out, RegWrite_out} !== {32'h42, 5'd7, 1'b1}) begin
      tests_failed++;
      $display("FAIL stall_release: got wb=%h rd=%0d rw=%b required 42/7/1",
               WBData_out, rd_out, RegWrite_out);
    end
    drive(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd8, 1'b1, 1'b1);
    tests_run++;
    if (ReadData_out !== 32'h0BADF00D) begin
      tests_failed++;
      $display("FAIL stall_no_write: got %h required 0badf00d", ReadData_out);
    end
  endtask

  task automatic test_wrap;
    drive(1'b0, 1'b1, 3'b010, 32'h1004, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 3'b010, 32'h0004, 32'h0, 5'd10, 1'b1, 1'b1);
    tests_run++;
    if (ReadData_out !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL wrap: got %h required cafef00d", ReadData_out);
    end
  endtask

  task automatic test_back_to_back;
    // Read+write together acts as a store; the following load sees it.
    drive(1'b1, 1'b1, 3'b010, 32'h10, 32'h01010101, 5'd11, 1'b1, 1'b1);
    tests_run++;
    if ({ReadData_out, WBData_out} !== {32'h0, 32'h0}) begin
      tests_failed++;
      $display("FAIL rw_both: got rdata=%h wb=%h required 0/0", ReadData_out, WBData_out);
    end
    drive(1'b0, 1'b1, 3'b101, 32'h12, 32'h0000A5C3, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd12, 1'b1, 1'b1);
    tests_run++;
    if (ReadData_out !== 32'hA5C30101) begin
      tests_failed++;
      $display("FAIL b2b_sh_lw: got %h required a5c30101", ReadData_out);
    end
  endtask

  initial begin
    reset = 1'b0; stall_in = 1'b0;
    MemOp_in = '0; MemRead_in = 1'b0; MemWrite_in = 1'b0; ALUResult_in = '0;
    WriteData_in = '0; rd_in = '0; RegWrite_in = 1'b0; MemtoReg_in = 1'b0;
    test_reset();
    test_word();
    test_subword();
    test_misalign();
    test_stall();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
